// File: rtl/gb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : gb_bus_responder
// Description : Memory-side responder for the SM83 8-bit data bus. It decodes
//               the boot-ROM overlay, HRAM, IE and the FF50 boot latch
//               internally, forwards all other accesses to the external port,
//               and runs the FF46 OAM DMA engine, which owns the external port
//               while it is active.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_bus_responder #(
    parameter int BOOT_SIZE = 256,
    parameter int DMA_LEN   = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [7:0]  boot_addr,
    input  logic [7:0]  boot_rdata,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active,
    output logic        boot_en
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } dma_state_e;

    // Read-data source selected when a read is accepted
    localparam logic [1:0]  c_sel_boot = 2'd0;
    localparam logic [1:0]  c_sel_ext  = 2'd1;
    localparam logic [1:0]  c_sel_int  = 2'd2;
    localparam logic [7:0]  c_last_idx = 8'(DMA_LEN - 1);
    localparam logic [16:0] c_boot_lim = 17'(BOOT_SIZE);

    // State
    dma_state_e  state_q;
    logic [7:0]  src_hi_q;
    logic [7:0]  idx_q;
    logic        oam_we_q;
    logic [7:0]  oam_addr_q;
    logic        boot_en_q;
    logic [7:0]  ie_q;
    logic [7:0]  hram_q [0:126];
    logic        rd_pend_q;
    logic [1:0]  rd_sel_q;
    logic [7:0]  int_rdata_q;
    logic [7:0]  rdata_hold_q;

    // Next-state for the read path
    logic        rd_pend_d;
    logic [1:0]  rd_sel_d;
    logic [7:0]  int_rdata_d;

    // Decode
    logic        w_dma;
    logic        w_is_ff46;
    logic        w_is_ff50;
    logic        w_is_ie;
    logic        w_is_hram;
    logic        w_is_int;
    logic        w_in_boot;
    logic        w_rd;
    logic        w_cpu_ext_rd;
    logic        w_cpu_ext_wr;
    logic [7:0]  w_rd_mux;

    assign w_dma     = (state_q == S_XFER);
    assign w_is_ff46 = (cpu_addr == 16'hFF46);
    assign w_is_ff50 = (cpu_addr == 16'hFF50);
    assign w_is_ie   = (cpu_addr == 16'hFFFF);
    assign w_is_hram = (cpu_addr[15:7] == 9'h1FF) && !w_is_ie;
    assign w_is_int  = w_is_ff46 || w_is_ff50 || w_is_ie || w_is_hram;
    assign w_in_boot = boot_en_q && ({1'b0, cpu_addr} < c_boot_lim);

    // A simultaneous write wins; the read is discarded
    assign w_rd = cpu_rd && !cpu_wr;

    // While DMA runs, every CPU access that would need the external port is
    // either below FF00 (blocked) or loses contention to the DMA read, so the
    // CPU never reaches ext during a transfer.
    assign w_cpu_ext_rd = w_rd && !w_is_int && !w_dma && !w_in_boot;
    assign w_cpu_ext_wr = cpu_wr && !w_is_int && !w_dma;

    // External port arbitration: DMA read first, then CPU-forwarded access
    always_comb begin
        ext_addr  = 16'h0000;
        ext_rd    = 1'b0;
        ext_wr    = 1'b0;
        ext_wdata = 8'h00;
        if (!rst) begin
            if (w_dma) begin
                ext_rd   = 1'b1;
                ext_addr = {src_hi_q, idx_q};
            end else if (w_cpu_ext_rd || w_cpu_ext_wr) begin
                ext_addr  = cpu_addr;
                ext_rd    = w_cpu_ext_rd;
                ext_wr    = w_cpu_ext_wr;
                ext_wdata = w_cpu_ext_wr ? cpu_wdata : 8'h00;
            end
        end
    end

    assign boot_addr = cpu_addr[7:0];

    // Pick the read source and capture internal data at the time of the read
    always_comb begin
        rd_pend_d   = w_rd;
        rd_sel_d    = c_sel_int;
        int_rdata_d = 8'hFF;
        if (w_is_int) begin
            if (w_is_ff46) begin
                int_rdata_d = src_hi_q;
            end else if (w_is_ff50) begin
                int_rdata_d = {7'h7F, ~boot_en_q};
            end else if (w_is_ie) begin
                int_rdata_d = ie_q;
            end else begin
                int_rdata_d = hram_q[cpu_addr[6:0]];
            end
        end else if (w_dma) begin
            rd_sel_d = c_sel_int;  // blocked or contended: returns 0xFF
        end else if (w_in_boot) begin
            rd_sel_d = c_sel_boot;
        end else begin
            rd_sel_d = c_sel_ext;
        end
    end

    // Output mux for the cycle after a read
    always_comb begin
        case (rd_sel_q)
            c_sel_boot: w_rd_mux = boot_rdata;
            c_sel_ext:  w_rd_mux = ext_rdata;
            default:    w_rd_mux = int_rdata_q;
        endcase
    end

    assign cpu_rdata = rd_pend_q ? w_rd_mux : rdata_hold_q;

    // Read-path registers; the hold register keeps the last delivered byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q    <= 1'b0;
            rd_sel_q     <= c_sel_int;
            int_rdata_q  <= 8'hFF;
            rdata_hold_q <= 8'hFF;
        end else begin
            rd_pend_q <= rd_pend_d;
            if (rd_pend_d) begin
                rd_sel_q    <= rd_sel_d;
                int_rdata_q <= int_rdata_d;
            end
            if (rd_pend_q) begin
                rdata_hold_q <= w_rd_mux;
            end
        end
    end

    // Boot latch and IE register
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_en_q <= 1'b1;
            ie_q      <= 8'h00;
        end else if (cpu_wr) begin
            if (w_is_ff50 && (cpu_wdata != 8'h00)) begin
                boot_en_q <= 1'b0;
            end
            if (w_is_ie) begin
                ie_q <= cpu_wdata;
            end
        end
    end

    // HRAM storage, contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && cpu_wr && w_is_hram) begin
            hram_q[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

    // OAM DMA engine: one ext read per cycle, OAM write one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_hi_q   <= 8'h00;
            idx_q      <= 8'h00;
            oam_we_q   <= 1'b0;
            oam_addr_q <= 8'h00;
        end else begin
            oam_we_q <= w_dma;
            if (w_dma) begin
                oam_addr_q <= idx_q;
            end
            if (cpu_wr && w_is_ff46) begin
                src_hi_q <= cpu_wdata;
                idx_q    <= 8'h00;
                state_q  <= S_XFER;
            end else if (w_dma) begin
                idx_q <= idx_q + 8'd1;
                if (idx_q == c_last_idx) begin
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign oam_we     = oam_we_q;
    assign oam_addr   = oam_addr_q;
    // Ext memory answers one cycle after the DMA read, aligned with oam_we
    assign oam_wdata  = oam_we_q ? ext_rdata : 8'h00;
    assign dma_active = w_dma;
    assign boot_en    = boot_en_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_bus_responder
// Description : Scoreboard bench for gb_bus_responder with boot-ROM and
//               external memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [7:0]  boot_addr;
    logic [7:0]  boot_rdata;
    logic [15:0] ext_addr;
    logic        ext_rd;
    logic        ext_wr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic        boot_en;

    always #5 clk = ~clk;

    gb_bus_responder #(
        .BOOT_SIZE(256),
        .DMA_LEN  (160)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .boot_addr (boot_addr),
        .boot_rdata(boot_rdata),
        .ext_addr  (ext_addr),
        .ext_rd    (ext_rd),
        .ext_wr    (ext_wr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .dma_active(dma_active),
        .boot_en   (boot_en)
    );

    // Boot ROM model: byte = address ^ 0x3C, synchronous read
    always @(posedge clk) boot_rdata <= boot_addr ^ 8'h3C;

    // External memory model, synchronous read-before-write
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ext_rd) ext_rdata <= mem[ext_addr];
        if (ext_wr) mem[ext_addr] = ext_wdata;
    end

    int          n_pass  = 0;
    int          n_total = 0;
    int          oam_cnt = 0;
    bit          rd_prev = 1'b0;
    logic [7:0]  exp_rd_q [$];
    logic [15:0] exp_oam_q [$];
    logic [7:0]  exp_b;
    logic [15:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got event with empty scoreboard, expected none", name);
    endtask

    // Monitor: pops expected read data and OAM writes as the DUT presents them
    always @(negedge clk) begin
        if (rd_prev) begin
            if (exp_rd_q.size() == 0) fail_now("cpu_rdata_sb");
            else begin
                exp_b = exp_rd_q.pop_front();
                check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, exp_b});
            end
        end
        rd_prev = cpu_rd && !cpu_wr && !rst;
        if (oam_we === 1'b1) begin
            oam_cnt++;
            if (exp_oam_q.size() == 0) fail_now("oam_sb");
            else begin
                exp_w = exp_oam_q.pop_front();
                check("oam_addr_data", {16'h0, oam_addr, oam_wdata}, {16'h0, exp_w});
            end
        end
    end

    task automatic idle();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = 1'b0;
        next(); idle();
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        cpu_addr = a; cpu_rd = 1'b1; cpu_wr = 1'b0;
        exp_rd_q.push_back(e);
        next(); idle();
    endtask

    // Runs ncyc cycles after an FF46 write, checking the ext read sequence
    task automatic dma_run(input int restart_at, input bit probe, input int ncyc,
                           output int errs, output int act_cnt, output int last_oam);
        logic        exp_act;
        logic [15:0] exp_a;
        errs = 0; act_cnt = 0; last_oam = 0;
        for (int k = 1; k <= ncyc; k++) begin
            idle();
            if (restart_at != 0 && k == restart_at) begin
                cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_wr = 1'b1;
            end
            if (probe) begin
                case (k)
                    10: begin cpu_addr = 16'hC123; cpu_rd = 1'b1; exp_rd_q.push_back(8'hFF); end
                    11: begin cpu_addr = 16'hD000; cpu_wdata = 8'h55; cpu_wr = 1'b1; end
                    12: begin cpu_addr = 16'hFF90; cpu_wdata = 8'h6B; cpu_wr = 1'b1; end
                    13: begin cpu_addr = 16'hFF90; cpu_rd = 1'b1; exp_rd_q.push_back(8'h6B); end
                    14: begin cpu_addr = 16'hFF46; cpu_rd = 1'b1; exp_rd_q.push_back(8'hC0); end
                    15: begin cpu_addr = 16'hFF40; cpu_rd = 1'b1; exp_rd_q.push_back(8'hFF); end
                    16: begin cpu_addr = 16'hFF50; cpu_rd = 1'b1; exp_rd_q.push_back(8'hFF); end
                    default: ;
                endcase
            end
            #1;
            if (restart_at != 0 && k > restart_at) begin
                exp_act = (k - restart_at <= 160);
                exp_a   = {8'hD0, 8'(k - restart_at - 1)};
            end else begin
                exp_act = (k <= 160);
                exp_a   = {8'hC0, 8'(k - 1)};
            end
            if (dma_active !== exp_act) errs++;
            if (exp_act) begin
                if (ext_rd !== 1'b1 || ext_wr !== 1'b0 || ext_addr !== exp_a) errs++;
            end else if (ext_rd !== 1'b0 || ext_wr !== 1'b0) begin
                errs++;
            end
            if (dma_active === 1'b1) act_cnt++;
            if (oam_we === 1'b1) last_oam = k;
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, act_cnt, last_oam, snap;
        idle();
        rst = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + i] = 8'(i) ^ 8'hA7;
        end
        mem[16'h0005] = 8'h77;
        repeat (3) next();

        // Reset values
        check("rst_cpu_rdata", {24'h0, cpu_rdata}, 32'hFF);
        check("rst_ext", {7'h0, ext_rd, ext_wr, ext_addr, ext_wdata}, 32'h0);
        check("rst_oam", {15'h0, oam_we, oam_addr, oam_wdata}, 32'h0);
        check("rst_dma_boot", {30'h0, dma_active, boot_en}, 32'h1);
        rst = 1'b0;
        next();

        // Boot overlay
        cpu_addr = 16'h0005; cpu_rd = 1'b1; exp_rd_q.push_back(8'h39);
        #1;
        check("boot_addr", {24'h0, boot_addr}, 32'h05);
        check("boot_no_ext", {31'h0, ext_rd}, 32'h0);
        next(); idle();
        rd(16'hFF46, 8'h00);
        rd(16'hFFFF, 8'h00);
        rd(16'hFF50, 8'hFE);
        wr(16'hFF50, 8'h01);
        check("boot_en_cleared", {31'h0, boot_en}, 32'h0);
        cpu_addr = 16'h0005; cpu_rd = 1'b1; exp_rd_q.push_back(8'h77);
        #1;
        check("postboot_ext", {15'h0, ext_rd, ext_addr}, {15'h0, 1'b1, 16'h0005});
        next(); idle();
        rd(16'hFF50, 8'hFF);

        // HRAM / IE
        cpu_addr = 16'hFF80; cpu_wdata = 8'hA5; cpu_wr = 1'b1;
        #1;
        check("hram_wr_no_ext", {30'h0, ext_rd, ext_wr}, 32'h0);
        next(); idle();
        wr(16'hFFFF, 8'h1F);
        wr(16'hFFFE, 8'h3C);
        cpu_addr = 16'hFF80; cpu_rd = 1'b1; exp_rd_q.push_back(8'hA5);
        #1;
        check("hram_rd_no_ext", {30'h0, ext_rd, ext_wr}, 32'h0);
        next(); idle();
        rd(16'hFFFE, 8'h3C);
        rd(16'hFFFF, 8'h1F);
        // Read and write together: write wins, rdata holds
        cpu_addr = 16'hFF81; cpu_wdata = 8'h99; cpu_wr = 1'b1; cpu_rd = 1'b1;
        next(); idle();
        check("rdwr_hold", {24'h0, cpu_rdata}, 32'h1F);
        rd(16'hFF81, 8'h99);

        // Plain external write then read back
        cpu_addr = 16'h8000; cpu_wdata = 8'h42; cpu_wr = 1'b1;
        #1;
        check("ext_wr_path", {6'h0, ext_wr, ext_rd, ext_addr, ext_wdata}, {6'h0, 2'b10, 16'h8000, 8'h42});
        next(); idle();
        rd(16'h8000, 8'h42);

        // DMA from C0 with blocking/contention probes
        for (int i = 0; i < 160; i++) exp_oam_q.push_back({8'(i), 8'(i) ^ 8'h5A});
        wr(16'hFF46, 8'hC0);
        dma_run(0, 1'b1, 170, errs, act_cnt, last_oam);
        check("dma1_ext_seq_errs", errs, 0);
        check("dma1_active_cycles", act_cnt, 160);
        check("dma1_last_oam", last_oam, 161);
        check("dma1_oam_drained", exp_oam_q.size(), 0);
        rd(16'hD000, 8'hA7);
        rd(16'hFF90, 8'h6B);

        // Restart mid-transfer
        for (int i = 0; i < 50; i++) exp_oam_q.push_back({8'(i), 8'(i) ^ 8'h5A});
        for (int i = 0; i < 160; i++) exp_oam_q.push_back({8'(i), 8'(i) ^ 8'hA7});
        wr(16'hFF46, 8'hC0);
        dma_run(50, 1'b0, 220, errs, act_cnt, last_oam);
        check("dma2_ext_seq_errs", errs, 0);
        check("dma2_active_cycles", act_cnt, 210);
        check("dma2_last_oam", last_oam, 211);
        check("dma2_oam_drained", exp_oam_q.size(), 0);

        // Reset at idx 80
        for (int i = 0; i < 80; i++) exp_oam_q.push_back({8'(i), 8'(i) ^ 8'h5A});
        wr(16'hFF46, 8'hC0);
        repeat (80) next();
        #1;
        check("rst_idx80_addr", {15'h0, ext_rd, ext_addr}, {15'h0, 1'b1, 16'hC050});
        rst = 1'b1;
        next();
        snap = oam_cnt;
        check("midrst_oam", {15'h0, oam_we, oam_addr, oam_wdata}, 32'h0);
        check("midrst_dma_boot", {30'h0, dma_active, boot_en}, 32'h1);
        check("midrst_ext", {7'h0, ext_rd, ext_wr, ext_addr, ext_wdata}, 32'h0);
        check("midrst_cpu_rdata", {24'h0, cpu_rdata}, 32'hFF);
        next();
        rst = 1'b0;
        repeat (5) next();
        check("midrst_no_oam", oam_cnt - snap, 0);
        check("midrst_oam_drained", exp_oam_q.size(), 0);
        rd(16'h0005, 8'h39);
        rd(16'hFF46, 8'h00);
        next();
        check("rd_sb_drained", exp_rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
